// File: rtl/ej32_fetch.sv
// ej32_fetch: bytecode instruction fetcher for the eJ32 core.
//
// Reads the program byte stream from a byte-wide instruction memory with a
// single-cycle read latency. Each opcode is classified by its operand count
// (JVM opcodes plus the FVM extensions 'hca-'hd1). The opcode and its operand
// bytes are collected into one instruction, which is presented to the decoder
// over a valid/ready handshake. A redirect from execute (jmp) restarts the
// byte stream at jmp_a from any state.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   mem_a, mem_rd       byte address and read strobe to instruction memory
//   mem_di              read data, valid one cycle after mem_rd
//   jmp, jmp_a          redirect request and target pc
//   op_valid, op_ready  instruction handshake towards the decoder
//   op, opd             opcode byte, operand bytes (big-endian, zero-extended)
//   op_pc, op_len       opcode address, operand byte count (0-4)
//   op_err              unsupported opcode; fetch halts after it is consumed
//
// Optional build macro EJ32_FETCH_STAT_EN adds op_cnt, a 32-bit count of
// completed handshakes (cleared only by rst).
module ej32_fetch #(
  parameter logic [16:0] RST_PC  = 17'h0,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [16:0] mem_a,
  output logic        mem_rd,
  input  logic [7:0]  mem_di,
  input  logic        jmp,
  input  logic [16:0] jmp_a,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [7:0]  op,
  output logic [31:0] opd,
  output logic [16:0] op_pc,
  output logic [2:0]  op_len,
  output logic        op_err
`ifdef EJ32_FETCH_STAT_EN
  ,
  output logic [31:0] op_cnt
`endif
);

  // Opcodes with one-off operand counts.
  localparam logic [7:0] OpBipush     = 8'h10;
  localparam logic [7:0] OpSipush     = 8'h11;
  localparam logic [7:0] OpLdc        = 8'h12;
  localparam logic [7:0] OpLdcW       = 8'h13;
  localparam logic [7:0] OpLdc2W      = 8'h14;
  localparam logic [7:0] OpIinc       = 8'h84;
  localparam logic [7:0] OpRet        = 8'ha9;
  localparam logic [7:0] OpTableSw    = 8'haa;
  localparam logic [7:0] OpLookupSw   = 8'hab;
  localparam logic [7:0] OpInvokeIf   = 8'hb9;
  localparam logic [7:0] OpInvokeDyn  = 8'hba;
  localparam logic [7:0] OpNew        = 8'hbb;
  localparam logic [7:0] OpNewArray   = 8'hbc;
  localparam logic [7:0] OpANewArray  = 8'hbd;
  localparam logic [7:0] OpCheckCast  = 8'hc0;
  localparam logic [7:0] OpInstanceOf = 8'hc1;
  localparam logic [7:0] OpWide       = 8'hc4;
  localparam logic [7:0] OpMultiANew  = 8'hc5;
  localparam logic [7:0] OpIfNull     = 8'hc6;
  localparam logic [7:0] OpIfNonNull  = 8'hc7;
  localparam logic [7:0] OpGotoW      = 8'hc8;
  localparam logic [7:0] OpJsrW       = 8'hc9;
  localparam logic [7:0] OpDonext     = 8'hca;
  localparam logic [7:0] OpLdi        = 8'hcb;
  localparam logic [7:0] OpExt        = 8'hcf;

  typedef enum logic [2:0] {
    StIssue,
    StOp,
    StOpd,
    StOut,
    StHalt
  } state_e;

  state_e      state_q;
  logic [16:0] pc_q;
  logic [2:0]  cnt_q;

  logic [2:0]  dec_len;
  logic        dec_err;

  // The read pipeline below assumes data returns exactly one cycle after mem_rd.
  a_mem_lat: assert property (@(posedge clk) MEM_LAT == 1);

  // Operand count of the byte currently on mem_di (only meaningful in StOp).
  always_comb begin
    dec_len = 3'd0;
    dec_err = 1'b0;
    case (mem_di) inside
      OpBipush, OpLdc, [8'h15:8'h19], [8'h36:8'h3a], OpRet, OpNewArray, OpExt:
        dec_len = 3'd1;
      OpSipush, OpLdcW, OpLdc2W, OpIinc, [8'h99:8'ha8], [8'hb2:8'hb8], OpNew,
      OpANewArray, OpCheckCast, OpInstanceOf, OpIfNull, OpIfNonNull, OpDonext:
        dec_len = 3'd2;
      OpMultiANew:
        dec_len = 3'd3;
      OpInvokeIf, OpInvokeDyn, OpGotoW, OpJsrW, OpLdi:
        dec_len = 3'd4;
      OpTableSw, OpLookupSw, OpWide, [8'hd2:8'hff]:
        dec_err = 1'b1;
      default: ;
    endcase
  end

  // Memory requests come straight from the state so that data for a read
  // issued in this cycle is on mem_di in the next one. A redirect suppresses
  // the read since its data would be discarded anyway.
  always_comb begin
    mem_a  = pc_q;
    mem_rd = 1'b0;
    if (!rst && !jmp) begin
      case (state_q)
        StIssue: mem_rd = 1'b1;
        StOp:    mem_rd = !dec_err && (dec_len != 3'd0);
        StOpd:   mem_rd = (cnt_q > 3'd1);
        default: mem_rd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIssue;
      pc_q     <= RST_PC;
      cnt_q    <= 3'd0;
      op_valid <= 1'b0;
      op       <= 8'h00;
      opd      <= 32'h0;
      op_pc    <= 17'h0;
      op_len   <= 3'd0;
      op_err   <= 1'b0;
    end else if (jmp) begin
      // Redirect wins over everything, including a handshake in this cycle.
      state_q  <= StIssue;
      pc_q     <= jmp_a;
      cnt_q    <= 3'd0;
      op_valid <= 1'b0;
      opd      <= 32'h0;
      op_err   <= 1'b0;
    end else begin
      case (state_q)
        StIssue: begin
          pc_q    <= pc_q + 17'd1;
          state_q <= StOp;
        end
        StOp: begin
          op     <= mem_di;
          op_pc  <= pc_q - 17'd1;
          op_len <= dec_len;
          op_err <= dec_err;
          opd    <= 32'h0;
          if (dec_err || dec_len == 3'd0) begin
            op_valid <= 1'b1;
            state_q  <= StOut;
          end else begin
            pc_q    <= pc_q + 17'd1;
            cnt_q   <= dec_len;
            state_q <= StOpd;
          end
        end
        StOpd: begin
          opd   <= {opd[23:0], mem_di};
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q > 3'd1) begin
            pc_q <= pc_q + 17'd1;
          end else begin
            op_valid <= 1'b1;
            state_q  <= StOut;
          end
        end
        StOut: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            opd      <= 32'h0;
            state_q  <= op_err ? StHalt : StIssue;
          end
        end
        StHalt: ;
        default: state_q <= StIssue;
      endcase
    end
  end

`ifdef EJ32_FETCH_STAT_EN
  // Counts consumed instructions, including one consumed alongside a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt <= 32'h0;
    end else if (op_valid && op_ready) begin
      op_cnt <= op_cnt + 32'd1;
    end
  end
`endif

endmodule
